// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit.
// Next-PC selector encoding and target alignment helpers.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BR,
    PC_LD,
    PC_RET
  } pc_sel_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] lo);
    return |(lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Built only when PC_RAS_EN is defined.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW:0]     cnt_q, cnt_d;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = wp_q + 1'b1;
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      wp_d  = wp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // wp_q is the next write slot, so the top lives one below it
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

  assign top   = mem_q[wp_q - 1'b1];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: priority next-PC select, alignment check, PC register.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_inc,
  input  logic            pc_ld,
  input  logic [XLEN-1:0] pc_in,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_off,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc_out,
  output logic            align_err,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] KEEP = ~{{(XLEN-2){1'b0}}, ALIGN_MASK};

  pc_sel_e         sel;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic            ret_ok;
  logic [XLEN-1:0] ras_top;
  logic            ras_emp;

`ifdef PC_RAS_EN
  logic push, pop;

  assign push   = !stall && pc_ld && call;
  assign pop    = !stall && (sel == PC_RET) && !ras_emp;
  assign ret_ok = ret;

  pc_ras #(
    .XLEN (XLEN),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(pc_q + XLEN'(INC)),
    .top      (ras_top),
    .empty    (ras_emp),
    .full     (ras_full)
  );
`else
  logic unused_ras;

  assign unused_ras = call ^ ret;
  assign ret_ok     = 1'b0;
  assign ras_top    = '0;
  assign ras_emp    = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    if (pc_ld)         sel = PC_LD;
    else if (ret_ok)   sel = PC_RET;
    else if (br_taken) sel = PC_BR;
    else if (pc_inc)   sel = PC_INC;
    else               sel = PC_HOLD;
  end

  always_comb begin
    logic [XLEN-1:0] raw;
    logic            bad;
    raw  = pc_q;
    bad  = 1'b0;
    pc_d = pc_q;
    unique case (sel)
      PC_INC: begin
        raw  = pc_q + XLEN'(INC);
        pc_d = raw & KEEP;
      end
      PC_BR: begin
        raw  = pc_q + br_off;
        bad  = misaligned(raw[1:0]);
        pc_d = raw & KEEP;
      end
      PC_LD: begin
        raw  = pc_in;
        bad  = misaligned(raw[1:0]);
        pc_d = raw & KEEP;
      end
      PC_RET: begin
        // an underflowing return holds the PC and flags the error
        bad  = ras_emp;
        pc_d = ras_emp ? pc_q : (ras_top & KEEP);
      end
      default: ;
    endcase
    err_d = err_q | bad;
    if (stall) begin
      pc_d  = pc_q;
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc_out    = pc_q;
  assign align_err = err_q;
  assign ras_empty = ras_emp;

endmodule
